// File: rtl/spdif_subframe_enc.sv
// S/PDIF (IEC 60958 consumer) subframe encoder: one stereo PCM pair per frame, BMC serial out.
// Optional channel-status CRCC in bits 184-191 is built when SPDIF_CS_CRC_EN is defined.
module spdif_subframe_enc #(
  parameter int PCM_W   = 24,
  parameter bit COPY_OK = 1'b1,
  parameter bit FS_44K1 = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [PCM_W-1:0] pcm_L_i,
  input  logic [PCM_W-1:0] pcm_R_i,
  output logic             pcm_rd_o,
  output logic             spdif_tx_o
);

  localparam logic [7:0] PRE_B = 8'hE8;
  localparam logic [7:0] PRE_M = 8'hE2;
  localparam logic [7:0] PRE_W = 8'hE4;

  logic [6:0]  hc;
  logic [7:0]  fc;
  logic        sf, ph, wrap;
  logic [4:0]  slot;
  logic [23:0] aud_l, aud_r, aud;
  logic [23:0] l_mj, r_mj;
  logic        v_q, pol_q;
  logic        cs_bit, par, data_bit, pol, tx_nxt;
  logic [7:0]  pat;
  logic [31:0] sub_word;

  assign sf   = hc[6];
  assign slot = hc[5:1];
  assign ph   = hc[0];
  assign wrap = (hc == 7'd127);

  // Narrow samples are MSB-justified into the 24-bit audio field.
  assign l_mj = 24'(pcm_L_i) << (24 - PCM_W);
  assign r_mj = 24'(pcm_R_i) << (24 - PCM_W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc <= '0;
      fc <= '0;
    end else begin
      hc <= hc + 7'd1;
      if (wrap) fc <= (fc == 8'd191) ? 8'd0 : fc + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aud_l    <= '0;
      aud_r    <= '0;
      v_q      <= 1'b1;
      pcm_rd_o <= 1'b0;
    end else begin
      pcm_rd_o <= wrap & en_i;
      if (wrap) begin
        aud_l <= en_i ? l_mj : 24'd0;
        aud_r <= en_i ? r_mj : 24'd0;
        v_q   <= ~en_i;
      end
    end
  end

`ifdef SPDIF_CS_CRC_EN
  logic [7:0] crc_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h1D : 8'h00);
  endfunction

  // Advanced once per frame while the left C slot is on the line; frozen for 184..191.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= 8'hFF;
    end else if (hc == 7'd60) begin
      if (fc == 8'd0)        crc_q <= crc8_step(8'hFF, cs_bit);
      else if (fc < 8'd184)  crc_q <= crc8_step(crc_q, cs_bit);
    end
  end
`endif

  always_comb begin
    cs_bit = 1'b0;
    if (fc == 8'd2)  cs_bit = COPY_OK;
    if (fc == 8'd25) cs_bit = ~FS_44K1;
`ifdef SPDIF_CS_CRC_EN
    if (fc >= 8'd184) cs_bit = crc_q[3'(8'd191 - fc)];
`endif
  end

  assign aud      = sf ? aud_r : aud_l;
  assign par      = ^{aud, v_q, cs_bit};
  assign sub_word = {par, cs_bit, 1'b0, v_q, aud, 4'b0000};
  assign data_bit = sub_word[slot];

  // Line level at the end of the previous subframe sets preamble polarity.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                   pol_q <= 1'b0;
    else if (hc[5:0] == 6'd0)    pol_q <= spdif_tx_o;
  end

  always_comb begin
    pat    = sf ? PRE_W : ((fc == 8'd0) ? PRE_B : PRE_M);
    pol    = (hc[5:0] == 6'd0) ? spdif_tx_o : pol_q;
    tx_nxt = 1'b0;
    if (hc[5:3] == 3'd0) tx_nxt = pat[~hc[2:0]] ^ pol;
    else if (!ph)        tx_nxt = ~spdif_tx_o;
    else                 tx_nxt = spdif_tx_o ^ data_bit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) spdif_tx_o <= 1'b0;
    else       spdif_tx_o <= tx_nxt;
  end

endmodule

// File: tb/tb_spdif_subframe_enc.sv
// Scoreboard bench for spdif_subframe_enc: 24-bit/48k and 16-bit/44.1k instances side by side.
module tb_spdif_subframe_enc;
  localparam int NF = 194;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic en_i = 1'b0;
  logic [23:0] l1 = '0, r1 = '0;
  logic [15:0] l2 = '0, r2 = '0;
  logic rd1, rd2, tx1, tx2;

  always #5 clk_i = ~clk_i;

  spdif_subframe_enc #(.PCM_W(24), .COPY_OK(1'b1), .FS_44K1(1'b0)) u_d24 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pcm_L_i(l1), .pcm_R_i(r1),
    .pcm_rd_o(rd1), .spdif_tx_o(tx1));

  spdif_subframe_enc #(.PCM_W(16), .COPY_OK(1'b0), .FS_44K1(1'b1)) u_d16 (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .pcm_L_i(l2), .pcm_R_i(r2),
    .pcm_rd_o(rd2), .spdif_tx_o(tx2));

  typedef struct packed {
    logic [7:0]  pre;
    logic [23:0] aud;
    logic        v;
    logic        c;
  } exp_t;

  exp_t q1[$], q2[$];
  bit   exp_en [0:NF];
  int   n_chk = 0, n_fail = 0;
  bit   mon_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic cs_exp(input int fc, input bit copy, input bit fs441);
    logic [191:0] cs;
    logic [7:0]   crc;
    cs = '0;
    cs[2]  = copy;
    cs[25] = ~fs441;
`ifdef SPDIF_CS_CRC_EN
    crc = 8'hFF;
    for (int i = 0; i < 184; i++)
      if (crc[7] ^ cs[i]) crc = (crc << 1) ^ 8'h1D;
      else                crc = crc << 1;
    for (int j = 0; j < 8; j++) cs[184 + j] = crc[7 - j];
`else
    crc = 8'h00;
    cs[191:184] = crc;
`endif
    return cs[fc];
  endfunction

  task automatic push_frame(input int f, input bit en, input logic [23:0] a1, input logic [23:0] b1,
                            input logic [15:0] a2, input logic [15:0] b2);
    exp_t e;
    logic c1, c2;
    c1 = cs_exp(f % 192, 1'b1, 1'b0);
    c2 = cs_exp(f % 192, 1'b0, 1'b1);
    e.v = ~en;
    e.c = c1;
    e.pre = (f % 192 == 0) ? 8'hE8 : 8'hE2; e.aud = en ? a1 : 24'd0;            q1.push_back(e);
    e.pre = 8'hE4;                          e.aud = en ? b1 : 24'd0;            q1.push_back(e);
    e.c = c2;
    e.pre = (f % 192 == 0) ? 8'hE8 : 8'hE2; e.aud = en ? {a2, 8'h00} : 24'd0;   q2.push_back(e);
    e.pre = 8'hE4;                          e.aud = en ? {b2, 8'h00} : 24'd0;   q2.push_back(e);
  endtask

  // Decode one 64-half-cell subframe and compare with the scoreboard entry.
  task automatic chk_sub(input string tag, input logic [0:63] h, input logic lvl, input exp_t e);
    logic [7:0]  pre;
    logic [31:0] d;
    logic [23:0] aud;
    int miss;
    d = '0;
    miss = 0;
    for (int i = 0; i < 8; i++) pre[7 - i] = h[i] ^ lvl;
    for (int s = 4; s < 32; s++) begin
      d[s] = h[2*s] ^ h[2*s + 1];
      if (h[2*s] == h[2*s - 1]) miss++;
    end
    for (int i = 0; i < 24; i++) aud[i] = d[4 + i];
    chk({tag, " preamble"}, 32'(pre), 32'(e.pre));
    chk({tag, " audio"},    32'(aud), 32'(e.aud));
    chk({tag, " V"},        32'(d[28]), 32'(e.v));
    chk({tag, " U"},        32'(d[29]), 32'd0);
    chk({tag, " C"},        32'(d[30]), 32'(e.c));
    chk({tag, " P"},        32'(d[31]), 32'(^{e.aud, e.v, e.c}));
    chk({tag, " bmc_cell_edges"}, 32'(miss), 32'd0);
  endtask

  // Monitor: free-running from reset release, decodes both lines and checks strobes.
  initial begin
    logic [0:63] h1, h2;
    logic lv1, lv2, erd;
    exp_t e;
    int k;
    lv1 = 1'b0; lv2 = 1'b0; k = 0;
    @(negedge rst_i);
    for (int f = 0; f < NF; f++) begin
      for (int sf = 0; sf < 2; sf++) begin
        for (int i = 0; i < 64; i++) begin
          @(posedge clk_i);
          k++;
          @(negedge clk_i);
          h1[i] = tx1;
          h2[i] = tx2;
          erd = (k % 128 == 0) ? exp_en[k / 128] : 1'b0;
          chk($sformatf("rd24 k%0d", k), 32'(rd1), 32'(erd));
          chk($sformatf("rd16 k%0d", k), 32'(rd2), 32'(erd));
        end
        chk($sformatf("sb24 nonempty f%0d", f), 32'(q1.size() != 0), 32'd1);
        chk($sformatf("sb16 nonempty f%0d", f), 32'(q2.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk_sub($sformatf("d24 f%0d %s", f, sf ? "R" : "L"), h1, lv1, e);
        end
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk_sub($sformatf("d16 f%0d %s", f, sf ? "R" : "L"), h2, lv2, e);
        end
        lv1 = h1[63];
        lv2 = h2[63];
      end
    end
    mon_done = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit en_mid, en_fin;
    logic [23:0] a1, b1;
    logic [15:0] a2, b2;
    logic [7:0] bb1, bb2;
    int g, w;

    // Reset state: outputs low while rst_i is held.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("reset tx24", 32'(tx1), 32'd0);
      chk("reset tx16", 32'(tx2), 32'd0);
      chk("reset rd24", 32'(rd1), 32'd0);
      chk("reset rd16", 32'(rd2), 32'd0);
    end
    push_frame(0, 1'b0, 24'd0, 24'd0, 16'd0, 16'd0);
    rst_i = 1'b0;

    repeat (20) @(posedge clk_i);
    for (int f = 0; f < NF - 1; f++) begin
      @(negedge clk_i);
      g = f + 1;
      case (g)
        1: begin en_mid = 1; en_fin = 1; a1 = 24'h800001; b1 = 24'h000000; a2 = 16'hABCD; b2 = 16'h0000; end
        2: begin en_mid = 1; en_fin = 0; a1 = 24'h123456; b1 = 24'h654321; a2 = 16'h1234; b2 = 16'h5678; end
        3: begin en_mid = 1; en_fin = 1; a1 = 24'hFFFFFF; b1 = 24'h7FFFFF; a2 = 16'hFFFF; b2 = 16'h8000; end
        4: begin en_mid = 0; en_fin = 1; a1 = 24'h5A5A5A; b1 = 24'hA5A5A5; a2 = 16'h00FF; b2 = 16'hFF00; end
        default: begin
          en_mid = (g % 50 != 0); en_fin = en_mid;
          a1 = 24'(g * 24'h010307); b1 = ~a1;
          a2 = 16'(g * 16'h0301);   b2 = 16'(g);
        end
      endcase
      en_i = en_mid; l1 = a1; r1 = b1; l2 = a2; r2 = b2;
      exp_en[g] = en_fin;
      push_frame(g, en_fin, a1, b1, a2, b2);
      repeat (50) @(posedge clk_i);
      @(negedge clk_i);
      en_i = en_fin;
      repeat (78) @(posedge clk_i);
    end
    exp_en[NF] = en_i;

    w = 0;
    while (!mon_done && w < 2000) begin
      @(posedge clk_i);
      w++;
    end
    chk("monitor completed", 32'(mon_done), 32'd1);

    // Reset mid-frame while the line is high, then expect a fresh B preamble.
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (tx1 !== 1'b1 && w < 200);
    chk("line high before mid reset", 32'(tx1), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("mid reset tx24", 32'(tx1), 32'd0);
    chk("mid reset tx16", 32'(tx2), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      bb1[7 - i] = tx1;
      bb2[7 - i] = tx2;
    end
    chk("post reset preamble d24", 32'(bb1), 32'hE8);
    chk("post reset preamble d16", 32'(bb2), 32'hE8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
